// File: rtl/board_pkg.sv
// =============================================================================
//  Module   : board_pkg
//  Purpose  : Board geometry, tile codes and write-arbiter state encoding.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package board_pkg;

    localparam int BOARD_W     = 32;
    localparam int BOARD_H     = 24;
    localparam int BOARD_CELLS = BOARD_W * BOARD_H;
    localparam int ADDR_W      = 10;
    localparam int TILE_W      = 4;

    localparam logic [TILE_W-1:0] TILE_EMPTY  = 4'h0;
    localparam logic [TILE_W-1:0] TILE_PELLET = 4'h1;
    localparam logic [TILE_W-1:0] TILE_POWER  = 4'h2;
    localparam logic [TILE_W-1:0] TILE_PAC    = 4'h3;
    localparam logic [TILE_W-1:0] TILE_BLINKY = 4'h4;
    localparam logic [TILE_W-1:0] TILE_PINKY  = 4'h5;
    localparam logic [TILE_W-1:0] TILE_INKY   = 4'h6;
    localparam logic [TILE_W-1:0] TILE_CLYDE  = 4'h7;

    typedef enum logic [1:0] {
        BWA_IDLE  = 2'd0,
        BWA_CLEAR = 2'd1,
        BWA_DRAW  = 2'd2,
        BWA_ACK   = 2'd3
    } bwa_state_t;

    // A cell address is usable only if it lands inside the 32x24 board.
    function automatic logic cell_valid(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(BOARD_CELLS);
    endfunction

endpackage : board_pkg

`default_nettype wire

// File: rtl/board_write_arbiter_rr.sv
// =============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first set request at or above
//             the pointer, wrapping past the top.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [2*NUM_REQ-1:0] w_doubled;
    logic [2*NUM_REQ-1:0] w_rotated;
    int                   w_offset;
    int                   w_sum;

    // Rotating a doubled copy right by the pointer puts the pointer's
    // requester at bit 0, so the lowest set bit is the round-robin winner.
    assign w_doubled = {req, req};
    assign w_rotated = w_doubled >> rr_ptr;

    always_comb begin
        w_offset = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rotated[k]) begin
                w_offset = k;
            end
        end
        w_sum = int'(rr_ptr) + w_offset;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
    end

    assign winner = IDX_W'(w_sum);
    assign any    = |req;

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/board_write_arbiter.sv
// =============================================================================
//  Module   : board_write_arbiter
//  Purpose  : Shares the board tile RAM write port between movers, sequencing
//             each granted move as clear-old then draw-new, then acknowledging.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module board_write_arbiter
    import board_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   old_addr,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   new_addr,
    input  logic [NUM_REQ-1:0][TILE_W-1:0]   clear_data,
    input  logic [NUM_REQ-1:0][TILE_W-1:0]   draw_data,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             err,
    output logic                             busy,
    output logic                             wren,
    output logic [ADDR_W-1:0]                write_addr,
    output logic [TILE_W-1:0]                write_data
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    bwa_state_t           r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_winner;
    logic [ADDR_W-1:0]    r_old;
    logic [ADDR_W-1:0]    r_new;
    logic [TILE_W-1:0]    r_clear;
    logic [TILE_W-1:0]    r_draw;
    logic                 r_err_q;

    logic [c_IDX_W-1:0]   w_winner;
    logic                 w_any;
    logic [c_IDX_W-1:0]   w_next_ptr;
    logic [ADDR_W-1:0]    w_old_sel;
    logic [ADDR_W-1:0]    w_new_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_winner),
        .any     (w_any)
    );

    assign w_old_sel  = old_addr[w_winner];
    assign w_new_sel  = new_addr[w_winner];
    assign w_next_ptr = (w_winner == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= BWA_IDLE;
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_old    <= '0;
            r_new    <= '0;
            r_clear  <= '0;
            r_draw   <= '0;
            r_err_q  <= 1'b0;
        end else begin
            case (r_state)
                BWA_IDLE: begin
                    if (w_any) begin
                        r_winner <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                        r_old    <= w_old_sel;
                        r_new    <= w_new_sel;
                        r_clear  <= clear_data[w_winner];
                        r_draw   <= draw_data[w_winner];
                        // Off-board moves are rejected whole: no partial write.
                        if (!cell_valid(w_old_sel) || !cell_valid(w_new_sel)) begin
                            r_err_q <= 1'b1;
                            r_state <= BWA_ACK;
                        end else if (w_old_sel == w_new_sel) begin
                            r_err_q <= 1'b0;
                            r_state <= BWA_DRAW;
                        end else begin
                            r_err_q <= 1'b0;
                            r_state <= BWA_CLEAR;
                        end
                    end
                end
                BWA_CLEAR: r_state <= BWA_DRAW;
                BWA_DRAW:  r_state <= BWA_ACK;
                BWA_ACK:   r_state <= BWA_IDLE;
                default:   r_state <= BWA_IDLE;
            endcase
        end
    end

    // Outputs depend only on the state and latched fields, so reset clears
    // the write strobe immediately and inputs never reach the RAM port directly.
    always_comb begin
        wren       = 1'b0;
        write_addr = '0;
        write_data = '0;
        ack        = '0;
        err        = 1'b0;
        busy       = (r_state != BWA_IDLE);
        case (r_state)
            BWA_CLEAR: begin
                wren       = 1'b1;
                write_addr = r_old;
                write_data = r_clear;
            end
            BWA_DRAW: begin
                wren       = 1'b1;
                write_addr = r_new;
                write_data = r_draw;
            end
            BWA_ACK: begin
                ack = NUM_REQ'(1) << r_winner;
                err = r_err_q;
            end
            default: ;
        endcase
    end

endmodule : board_write_arbiter

`default_nettype wire

// File: tb/tb_board_write_arbiter.sv
// =============================================================================
//  Module   : tb_board_write_arbiter
//  Purpose  : Self-checking bench for board_write_arbiter against a
//             schedule-based reference model.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_board_write_arbiter;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req;
    logic [N-1:0][9:0]   old_addr;
    logic [N-1:0][9:0]   new_addr;
    logic [N-1:0][3:0]   clear_data;
    logic [N-1:0][3:0]   draw_data;
    logic [N-1:0]        ack;
    logic                err;
    logic                busy;
    logic                wren;
    logic [9:0]          write_addr;
    logic [3:0]          write_data;

    board_write_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .old_addr   (old_addr),
        .new_addr   (new_addr),
        .clear_data (clear_data),
        .draw_data  (draw_data),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .wren       (wren),
        .write_addr (write_addr),
        .write_data (write_data)
    );

    always #10 clk = ~clk;

    // Reference model: a grant expands into a list of per-cycle port images.
    typedef struct {
        int wren;
        int addr;
        int data;
        int ack;
        int err;
        int busy;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   m_ptr;
    int   ack_order[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(int w, int a, int d, int k, int e, int b);
        exp_t x;
        x.wren = w; x.addr = a; x.data = d; x.ack = k; x.err = e; x.busy = b;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur   = mk(0, 0, 0, 0, 0, 0);
        m_ptr = 0;
    endtask

    task automatic model_step();
        if (cur.busy == 0 && req != '0) begin
            int w = -1;
            int o, n;
            for (int i = 0; i < N; i++) begin
                int j = (m_ptr + i) % N;
                if (w < 0 && req[j]) w = j;
            end
            m_ptr = (w + 1) % N;
            o = int'(old_addr[w]);
            n = int'(new_addr[w]);
            if (o >= 768 || n >= 768) begin
                q.push_back(mk(0, 0, 0, 1 << w, 1, 1));
            end else begin
                if (o != n) q.push_back(mk(1, o, int'(clear_data[w]), 0, 0, 1));
                q.push_back(mk(1, n, int'(draw_data[w]), 0, 0, 1));
                q.push_back(mk(0, 0, 0, 1 << w, 0, 1));
            end
        end
        if (q.size() > 0) cur = q.pop_front();
        else              cur = mk(0, 0, 0, 0, 0, 0);
    endtask

    // One clock: model advances on the edge, outputs compared on the falling
    // edge, and requesters drop req on their acknowledge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("cyc_wren",  int'(wren),       cur.wren);
        chk("cyc_addr",  int'(write_addr), cur.addr);
        chk("cyc_data",  int'(write_data), cur.data);
        chk("cyc_ack",   int'(ack),        cur.ack);
        chk("cyc_err",   int'(err),        cur.err);
        chk("cyc_busy",  int'(busy),       cur.busy);
        for (int i = 0; i < N; i++) begin
            if (ack[i]) ack_order.push_back(i);
            if (cur.ack[i]) req[i] = 1'b0;
        end
    endtask

    // Hand-computed expectations pin both the model and the DUT.
    task automatic expect_lit(input string name, input int w, input int a,
                              input int d, input int k, input int e);
        chk({name, "_m_wren"}, cur.wren, w);
        chk({name, "_m_addr"}, cur.addr, a);
        chk({name, "_m_data"}, cur.data, d);
        chk({name, "_m_ack"},  cur.ack,  k);
        chk({name, "_m_err"},  cur.err,  e);
        chk({name, "_wren"}, int'(wren),       w);
        chk({name, "_addr"}, int'(write_addr), a);
        chk({name, "_data"}, int'(write_data), d);
        chk({name, "_ack"},  int'(ack),        k);
        chk({name, "_err"},  int'(err),        e);
    endtask

    task automatic drain();
        int n = 0;
        while ((cur.busy != 0 || req != '0) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("drain_timeout", n, 0);
    endtask

    task automatic clean_reset();
        reset = 1'b1;
        req   = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic post(input int i, input int o, input int n, input int c, input int d);
        old_addr[i]   = 10'(o);
        new_addr[i]   = 10'(n);
        clear_data[i] = 4'(c);
        draw_data[i]  = 4'(d);
        req[i]        = 1'b1;
    endtask

    initial begin
        int exp_order[5];
        int cnt;
        bit reraised;

        reset = 1'b1; req = '0;
        old_addr = '0; new_addr = '0; clear_data = '0; draw_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_wren", int'(wren), 0);
        chk("rst_addr", int'(write_addr), 0);
        chk("rst_data", int'(write_data), 0);
        chk("rst_ack",  int'(ack), 0);
        chk("rst_err",  int'(err), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        // Single move
        post(0, 495, 496, 0, 3);
        tick(); expect_lit("sm_clear", 1, 495, 0, 0, 0);
        tick(); expect_lit("sm_draw",  1, 496, 3, 0, 0);
        tick(); expect_lit("sm_ack",   0, 0, 0, 1, 0);
        tick(); expect_lit("sm_idle",  0, 0, 0, 0, 0);

        // Same cell
        post(2, 100, 100, 9, 5);
        tick(); expect_lit("same_draw", 1, 100, 5, 0, 0);
        tick(); expect_lit("same_ack",  0, 0, 0, 4, 0);
        tick();

        // Out of range, then pointer must have moved past requester 1
        post(1, 10, 768, 1, 2);
        tick(); expect_lit("oor_ack", 0, 0, 0, 2, 1);
        tick();
        post(1, 20, 21, 0, 3);
        post(2, 30, 31, 0, 4);
        tick(); expect_lit("oor_ptr", 1, 30, 0, 0, 0);
        drain();

        // Field change during service
        post(0, 200, 201, 0, 7);
        tick(); expect_lit("fc_clear", 1, 200, 0, 0, 0);
        new_addr[0] = 10'd300;
        tick(); expect_lit("fc_draw", 1, 201, 7, 0, 0);
        drain();

        // Reset in DRAW
        clean_reset();
        post(1, 5, 6, 0, 3);
        post(2, 50, 51, 0, 4);
        tick();
        tick(); expect_lit("rd_draw", 1, 6, 3, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("rd_wren", int'(wren), 0);
        chk("rd_busy", int'(busy), 0);
        chk("rd_ack",  int'(ack),  0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(); expect_lit("rd_regrant", 1, 5, 0, 0, 0);
        drain();

        // All four requesting after reset; 0 re-requests after its ack
        clean_reset();
        ack_order.delete();
        for (int i = 0; i < N; i++) post(i, 10 * i + 1, 10 * i + 2, 0, i + 3);
        cnt = 0; reraised = 0;
        while (ack_order.size() < 5 && cnt < 60) begin
            tick();
            cnt++;
            if (!reraised && ack_order.size() >= 1) begin
                req[0] = 1'b1;
                reraised = 1;
            end
        end
        chk("order_len", ack_order.size(), 5);
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5 && i < ack_order.size(); i++)
            chk("order", ack_order[i], exp_order[i]);
        drain();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 3 == 0)) begin
                    int o = ($urandom % 16 == 0) ? int'($urandom_range(768, 1023))
                                                 : int'($urandom_range(0, 767));
                    int n = ($urandom % 4 == 0) ? o : int'($urandom_range(0, 799));
                    post(i, o, n, int'($urandom % 16), int'($urandom % 16));
                end
            end
            if (cur.busy != 0 && ($urandom % 8 == 0)) begin
                int k = int'($urandom % N);
                new_addr[k] = 10'($urandom);
            end
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_board_write_arbiter

`default_nettype wire

// File: doc/board_write_arbiter.md
# board_write_arbiter

Shares the single write port of the board tile RAM (768 cells, 32×24, 4-bit tile codes) between several movers: Pac-Man, ghosts and pellet logic. Each mover posts a move request: old cell, new cell, tile to restore, tile to draw. The arbiter grants requesters round-robin and sequences the write pair (clear old, draw new) onto the RAM port. It then acknowledges the requester. It sits between the behaviour modules and the board RAM's `wren`/`wraddress`/`data` inputs, and replaces ad-hoc per-mover write sequencing in the top level.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.

Ports:
- `clk`, in, 1: system clock (CLOCK_50 domain).
- `reset`, in, 1: asynchronous, active-high.
- `req`, in, NUM_REQ: per-requester move request, level.
- `old_addr`, in, NUM_REQ×10 (packed `[NUM_REQ-1:0][9:0]`): cell currently occupied.
- `new_addr`, in, NUM_REQ×10: destination cell.
- `clear_data`, in, NUM_REQ×4: tile code written to `old_addr`.
- `draw_data`, in, NUM_REQ×4: tile code written to `new_addr`.
- `ack`, out, NUM_REQ: one-hot, one-cycle completion pulse.
- `err`, out, 1: qualified by `ack`; 1 means the request was rejected with no writes.
- `busy`, out, 1: high in any state other than IDLE.
- `wren`, out, 1: board RAM write enable.
- `write_addr`, out, 10: board RAM write address.
- `write_data`, out, 4: board RAM write data.

## Operation
- FSM states: IDLE, CLEAR, DRAW, ACK.
- **IDLE**
  - If any `req` bit is high, pick a winner: the first set bit at or after `rr_ptr`, searching upward with wrap.
  - Latch the winner index and its `old_addr`, `new_addr`, `clear_data` and `draw_data`.
  - Set `rr_ptr` to winner+1 mod NUM_REQ.
  - Next state:
    - ACK with `err_q`=1 if either address is ≥ 768.
    - Otherwise DRAW if `old_addr`==`new_addr` (skip the clear).
    - Otherwise CLEAR.
- **CLEAR**: `wren`=1, `write_addr`=latched old, `write_data`=latched clear. Next state DRAW.
- **DRAW**: `wren`=1, `write_addr`=latched new, `write_data`=latched draw. Next state ACK.
- **ACK**: `ack[winner]`=1 and `err`=`err_q`. Next state IDLE.
- Output decode:
  - `wren`, `write_addr`, `write_data`, `ack`, `err` and `busy` are decoded only from the state register and latched registers. No input reaches an output combinationally.
  - Outside CLEAR/DRAW: `wren`=0, `write_addr`=0, `write_data`=0.
- Latched fields are frozen from grant until IDLE. Input changes during service are ignored.
- Requester contract:
  - Hold `req` and all fields stable until `ack`.
  - Drop `req` in the cycle after `ack`.
  - If `req` is still high in IDLE, it is treated as a new request.
- `err` does not stop the round-robin rotation; the rejected requester still advances `rr_ptr`.

## Timing
- `req` sampled high in IDLE at edge T:
  - CLEAR in cycle T+1.
  - DRAW in cycle T+2.
  - ACK in cycle T+3.
  - IDLE in cycle T+4.
- Service cost per request:
  - 4 cycles for a normal move.
  - 3 cycles when old==new.
  - 2 cycles for an error (IDLE→ACK→IDLE).
- Throughput: one request per 4 cycles worst case. Back-to-back grants have no idle bubble beyond the IDLE cycle itself.
- Fairness: with all requesters continuously active, each is served once every NUM_REQ grants.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait with `req` held.
- Reset values: state=IDLE, `rr_ptr`=0, all latches 0, `wren`=0, `write_addr`=0, `write_data`=0, `ack`=0, `err`=0, `busy`=0.
- Reset mid-operation:
  - `wren` drops asynchronously.
  - No `ack` is issued.
  - The interrupted requester is not completed and must re-request.
  - A partial clear-without-draw is acceptable; the board is reinitialised on game start.

## Structure
- Shared package `board_pkg`:
  - `BOARD_W`=32, `BOARD_H`=24, `BOARD_CELLS`=768, `ADDR_W`=10, `TILE_W`=4.
  - Tile codes `TILE_EMPTY`=4'h0, `TILE_PAC`=4'h3, plus ghost and pellet codes.
  - FSM state enum `bwa_state_t`.
- One sub-module, `rr_arbiter`:
  - Combinational round-robin pick.
  - Inputs: `req` vector, `rr_ptr`.
  - Outputs: winner index and `any` flag.
  - Pointer register stays in the parent.

## Test plan
- **Single move:** `req[0]`, old=495, new=496, clear=0, draw=3 → writes (495,0) at T+1 and (496,3) at T+2; `ack`=0001 at T+3; `err`=0.
- **All four requesting after reset:** all `req` held, each dropped after its own `ack` → grant order 0,1,2,3; with `req[0]` re-raised, it is served after 3.
- **Same cell:** old=new=100, draw=5 → exactly one write (100,5) at T+1; `ack` at T+2.
- **Out-of-range:** new=768 → `ack` with `err`=1 at T+1; `wren` never asserts; `rr_ptr` advances.
- **Reset in DRAW:** assert `reset` during the DRAW cycle → `wren`=0 and `busy`=0 immediately; no `ack`; after release, `req[1]` is granted first from `rr_ptr`=0.
- **Field change mid-service:** change `new_addr` during CLEAR → DRAW still writes the originally latched address.
